// File: rtl/tinker_dmem_pipe.sv
// Byte-addressable memory: combinational instruction fetch and a pipelined valid/ready data port.
// Optional macro TINKER_DMEM_MISALIGN_EN makes misaligned data accesses legal.
module tinker_dmem_pipe #(
  parameter int MEM_BYTES = 524288,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int LATENCY   = 2,
  parameter int MAX_OUT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_is_store,
  output logic [4:0]        outstanding
);

  localparam int MA_W  = $clog2(MEM_BYTES);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [ADDR_W:0] MEM_END = (ADDR_W+1)'(MEM_BYTES);

  typedef struct packed {
    logic              valid;
    logic              err;
    logic              is_store;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  logic [7:0] mem [MEM_BYTES];

  // Instruction fetch
  logic [ADDR_W:0] if_end;
  logic [7:0]      fetch_byte [4];

  assign if_end = {1'b0, if_pc} + (ADDR_W+1)'(4);

  for (genvar gi = 0; gi < 4; gi++) begin : g_fetch
    assign fetch_byte[gi] = mem[if_pc[MA_W-1:0] + MA_W'(gi)];
  end

  assign if_inst = (if_end <= MEM_END) ?
                   {fetch_byte[3], fetch_byte[2], fetch_byte[1], fetch_byte[0]} : 32'd0;

  // Request decode
  logic [3:0]        req_bytes;
  logic [ADDR_W:0]   req_end;
  logic              range_err;
  logic              misalign;
  logic              req_err;
  logic [7:0]        lane_en;
  logic [DATA_W-1:0] load_data;
  logic              accept;
  logic              consume;
  logic [4:0]        outstanding_reg;

  assign req_bytes = 4'd1 << req_size;
  assign req_end   = {1'b0, req_addr} + (ADDR_W+1)'(req_bytes);
  assign range_err = req_end > MEM_END;
  assign misalign  = |(req_addr[2:0] & (req_bytes[2:0] - 3'd1));

`ifdef TINKER_DMEM_MISALIGN_EN
  assign req_err = range_err;
  logic unused_misalign;
  assign unused_misalign = misalign;
`else
  assign req_err = range_err | misalign;
`endif

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] lane_byte;
    assign lane_en[gi] = 4'(gi) < req_bytes;
    assign lane_byte   = mem[req_addr[MA_W-1:0] + MA_W'(gi)];
    assign load_data[8*gi +: 8] = lane_en[gi] ? lane_byte : 8'd0;
  end

  assign req_ready = (outstanding_reg < 5'(MAX_OUT)) && !reset;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int k = 0; k < 8; k++) begin
        if (lane_en[k])
          mem[req_addr[MA_W-1:0] + MA_W'(k)] <= req_wdata[8*k +: 8];
      end
    end
  end

  // Latency pipeline; the last stage bypasses straight to the port when the FIFO is empty
  rsp_t             pipe_reg [LATENCY];
  rsp_t             new_rsp;
  rsp_t             last_rsp;
  rsp_t             head_rsp;
  rsp_t             fifo_mem [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [4:0]       fifo_count_reg;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  always_comb begin
    new_rsp          = '0;
    new_rsp.valid    = accept;
    new_rsp.err      = req_err;
    new_rsp.is_store = req_we;
    new_rsp.rdata    = (req_we || req_err) ? '0 : load_data;
  end

  assign last_rsp   = pipe_reg[LATENCY-1];
  assign fifo_empty = (fifo_count_reg == 5'd0);
  assign head_rsp   = fifo_empty ? last_rsp : fifo_mem[rd_ptr_reg];

  assign rsp_valid    = head_rsp.valid;
  assign rsp_rdata    = head_rsp.valid ? head_rsp.rdata : '0;
  assign rsp_err      = head_rsp.valid & head_rsp.err;
  assign rsp_is_store = head_rsp.valid & head_rsp.is_store;
  assign outstanding  = outstanding_reg;

  assign consume = rsp_valid && rsp_ready;
  assign push    = last_rsp.valid && !(fifo_empty && consume);
  assign pop     = consume && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= last_rsp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++)
        pipe_reg[s] <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fifo_count_reg  <= '0;
      outstanding_reg <= '0;
    end else begin
      pipe_reg[0] <= new_rsp;
      for (int s = 1; s < LATENCY; s++)
        pipe_reg[s] <= pipe_reg[s-1];
      if (push)
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_OUT-1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MAX_OUT-1)) ? '0 : rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 5'd1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 5'd1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      case ({accept, consume})
        2'b10:   outstanding_reg <= outstanding_reg + 5'd1;
        2'b01:   outstanding_reg <= outstanding_reg - 5'd1;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_tinker_dmem_pipe.sv
// Directed bench for tinker_dmem_pipe at default parameters (LATENCY 2, MAX_OUT 4, 512 KiB).
module tb_tinker_dmem_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_is_store;
  logic [4:0]  outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tinker_dmem_pipe dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_inst(if_inst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_is_store(rsp_is_store), .outstanding(outstanding)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic [63:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic req_once(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic [63:0] wdata);
    drive(we, addr, size, wdata);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    idle();
  endtask

  // Waits (bounded) for a response at a negedge, checks it, lets it be consumed.
  task automatic wait_rsp(input string tag, input logic [63:0] rd, input logic err,
                          input logic st);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rdata"}, rsp_rdata, rd);
    chk({tag, "_err"}, 64'(rsp_err), 64'(err));
    chk({tag, "_store"}, 64'(rsp_is_store), 64'(st));
    $display("rsp %s rdata=%h err=%b store=%b", tag, rsp_rdata, rsp_err, rsp_is_store);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] exp_101;
    logic        exp_101_err;
    int          seen_valid;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Store then back-to-back load of the same bytes, latency 2
    drive(1'b1, 32'h100, 2'd3, 64'h1122334455667788);
    @(negedge clk);
    drive(1'b0, 32'h100, 2'd3, 64'd0);
    @(negedge clk);
    idle();
    chk("st8_lat_valid", 64'(rsp_valid), 64'd1);
    chk("st8_lat_store", 64'(rsp_is_store), 64'd1);
    chk("st8_lat_rdata", rsp_rdata, 64'd0);
    $display("rsp st8_100 rdata=%h err=%b store=%b", rsp_rdata, rsp_err, rsp_is_store);
    @(negedge clk);
    chk("ld8_lat_valid", 64'(rsp_valid), 64'd1);
    chk("ld8_lat_rdata", rsp_rdata, 64'h1122334455667788);
    chk("ld8_lat_err", 64'(rsp_err), 64'd0);
    chk("ld8_lat_store", 64'(rsp_is_store), 64'd0);
    $display("rsp ld8_100 rdata=%h err=%b store=%b", rsp_rdata, rsp_err, rsp_is_store);
    @(negedge clk);
    chk("ld8_drained", 64'(rsp_valid), 64'd0);
    chk("ld8_outstanding", 64'(outstanding), 64'd0);

    // Sized loads
    req_once("ld1_103", 1'b0, 32'h103, 2'd0, 64'd0);
    wait_rsp("ld1_103", 64'h55, 1'b0, 1'b0);
    req_once("ld2_102", 1'b0, 32'h102, 2'd1, 64'd0);
    wait_rsp("ld2_102", 64'h5566, 1'b0, 1'b0);

    // Backpressure: 5 loads offered, only MAX_OUT accepted
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h100 + 32'(i), 2'd0, 64'd0);
      @(negedge clk);
    end
    idle();
    chk("bp_outstanding", 64'(outstanding), 64'd4);
    chk("bp_ready", 64'(req_ready), 64'd0);
    chk("bp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_head", rsp_rdata, 64'h88);
    @(negedge clk);
    chk("bp_hold", rsp_rdata, 64'h88);
    chk("bp_hold_outstanding", 64'(outstanding), 64'd4);
    rsp_ready = 1'b1;
    wait_rsp("bp0", 64'h88, 1'b0, 1'b0);
    wait_rsp("bp1", 64'h77, 1'b0, 1'b0);
    wait_rsp("bp2", 64'h66, 1'b0, 1'b0);
    wait_rsp("bp3", 64'h55, 1'b0, 1'b0);
    chk("bp_end_outstanding", 64'(outstanding), 64'd0);
    chk("bp_end_ready", 64'(req_ready), 64'd1);
    chk("bp_end_valid", 64'(rsp_valid), 64'd0);

    // Errors and range boundary
`ifdef TINKER_DMEM_MISALIGN_EN
    exp_101     = 64'h44556677;
    exp_101_err = 1'b0;
`else
    exp_101     = 64'd0;
    exp_101_err = 1'b1;
`endif
    req_once("ld4_101", 1'b0, 32'h101, 2'd2, 64'd0);
    wait_rsp("ld4_101", exp_101, exp_101_err, 1'b0);
    req_once("st4_top", 1'b1, 32'h7FFFC, 2'd2, 64'hCAFEF00D);
    wait_rsp("st4_top", 64'd0, 1'b0, 1'b1);
    req_once("st8_top", 1'b1, 32'h7FFFC, 2'd3, 64'hFFFFFFFFFFFFFFFF);
    wait_rsp("st8_top", 64'd0, 1'b1, 1'b1);
    req_once("ld4_top", 1'b0, 32'h7FFFC, 2'd2, 64'd0);
    wait_rsp("ld4_top", 64'hCAFEF00D, 1'b0, 1'b0);
    req_once("ld1_oob", 1'b0, 32'h80000, 2'd0, 64'd0);
    wait_rsp("ld1_oob", 64'd0, 1'b1, 1'b0);
    if_pc = 32'h7FFFC;
    #1;
    chk("if_top", 64'(if_inst), 64'hCAFEF00D);
    if_pc = 32'h7FFFD;
    #1;
    chk("if_oob", 64'(if_inst), 64'd0);

    // Store visible on the fetch port the cycle after accept
    @(negedge clk);
    if_pc = 32'h2000;
    req_once("st4_2000", 1'b1, 32'h2000, 2'd2, 64'hDEADBEEF);
    chk("if_after_store", 64'(if_inst), 64'hDEADBEEF);
    wait_rsp("st4_2000", 64'd0, 1'b0, 1'b1);

    // Reset mid-burst with two requests in flight
    drive(1'b0, 32'h100, 2'd3, 64'd0);
    @(negedge clk);
    drive(1'b0, 32'h103, 2'd0, 64'd0);
    @(negedge clk);
    drive(1'b0, 32'h102, 2'd1, 64'd0);
    @(negedge clk);
    chk("burst_outstanding", 64'(outstanding), 64'd2);
    reset = 1'b1;
    drive(1'b1, 32'h100, 2'd3, 64'd0);
    #1;
    chk("burst_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    chk("burst_rst_valid", 64'(rsp_valid), 64'd0);
    chk("burst_rst_outstanding", 64'(outstanding), 64'd0);
    chk("burst_rst_rdata", rsp_rdata, 64'd0);
    chk("burst_rst_err", 64'(rsp_err), 64'd0);
    chk("burst_rst_store", 64'(rsp_is_store), 64'd0);
    #1;
    chk("burst_post_ready", 64'(req_ready), 64'd1);
    seen_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid++;
    end
    chk("burst_discarded", 64'(seen_valid), 64'd0);
    req_once("ld8_persist", 1'b0, 32'h100, 2'd3, 64'd0);
    wait_rsp("ld8_persist", 64'h1122334455667788, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
